// File: rtl/gray_sweep_ctrl.sv
// Sweep sequencer: steps a binary index from start_val to end_val (up or down)
// and streams each index with its Gray code as a valid/ready beat.
module gray_sweep_ctrl #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             dir,
    input  logic             wrap_en,
    input  logic [width-1:0] start_val,
    input  logic [width-1:0] end_val,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [width-1:0] b_out,
    output logic [width-1:0] g_out,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [width:0]   beat_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [width-1:0] b_one   = {{(width-1){1'b0}}, 1'b1};
    localparam logic [width:0]   cnt_one = {{width{1'b0}}, 1'b1};

    state_t           state_reg, state_next;
    logic [width-1:0] b_reg, b_next;
    logic [width-1:0] g_reg, g_next;
    logic [width:0]   cnt_reg, cnt_next;
    logic             ovf_reg, ovf_next;
    logic             dir_reg, dir_next;
    logic             wrap_reg, wrap_next;
    logic [width-1:0] end_reg, end_next;
    logic             at_limit;

    // Gray code is computed from the next index so the pair is registered together.
    genvar gi;
    generate
        for (gi = 0; gi < width - 1; gi++) begin : g_gray
            assign g_next[gi] = b_next[gi] ^ b_next[gi+1];
        end
    endgenerate
    assign g_next[width-1] = b_next[width-1];

    assign at_limit = dir_reg ? (b_reg == '0) : (b_reg == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            b_reg     <= '0;
            g_reg     <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
            dir_reg   <= 1'b0;
            wrap_reg  <= 1'b0;
            end_reg   <= '0;
        end else begin
            state_reg <= state_next;
            b_reg     <= b_next;
            g_reg     <= g_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
            dir_reg   <= dir_next;
            wrap_reg  <= wrap_next;
            end_reg   <= end_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        b_next     = b_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        dir_next   = dir_reg;
        wrap_next  = wrap_reg;
        end_next   = end_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    dir_next   = dir;
                    wrap_next  = wrap_en;
                    end_next   = end_val;
                    b_next     = start_val;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                    state_next = RUN;
                end
            end
            RUN: begin
                // Abort wins over a simultaneous accept and leaves counters untouched.
                if (abort) begin
                    state_next = IDLE;
                end else if (out_ready) begin
                    cnt_next = cnt_reg + cnt_one;
                    if (b_reg == end_reg) begin
                        state_next = DONE;
                    end else if (at_limit && !wrap_reg) begin
                        ovf_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        // Modular add/subtract gives the wrap to 0 / all-ones for free.
                        b_next = dir_reg ? (b_reg - b_one) : (b_reg + b_one);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign out_valid = (state_reg == RUN);
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);
    assign b_out     = b_reg;
    assign g_out     = g_reg;
    assign ovf       = ovf_reg;
    assign beat_cnt  = cnt_reg;

endmodule
